arbiter_request_front_end: RTL and testbench

Requester-side front end for the 2-request round-robin arbiter. It buffers transactions from two clients in per-client FIFOs and drives `requests[1:0]` from FIFO occupancy. On each grant it pops the granted client's head word into a single registered output stage with valid/ready. It sits between two producer clients and the arbiter/shared downstream consumer.

---
 rtl/arb_req_pkg.sv | 11 +
 rtl/request_fifo.sv | 62 ++++++
 rtl/arbiter_request_front_end.sv | 96 +++++++++
 tb/tb_arbiter_request_front_end.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_req_pkg.sv
// Shared client identifiers for the 2-client arbiter request front end.
package arb_req_pkg;

    localparam int unsigned NUM_CLIENTS = 2;

    typedef logic client_id_t;

    localparam client_id_t CLIENT0 = 1'b0;
    localparam client_id_t CLIENT1 = 1'b1;

endpackage

// File: rtl/request_fifo.sv
// Per-client FIFO: registered count drives ready/empty, head is read combinationally.
module request_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    output logic                     push_ready,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign push_ready = !full;
    assign head       = mem[rd_ptr];

    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arbiter_request_front_end.sv
// Buffers two clients, raises requests from FIFO occupancy and loads granted words
// into a single registered output stage; flags illegal grants stickily.
module arbiter_request_front_end
    import arb_req_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in0_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    input  logic [W-1:0] in1_data,
    output logic [1:0]   requests,
    input  logic [1:0]   grants,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_src,
    output logic         protocol_error
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  head0;
    logic [W-1:0]  head1;
    logic          empty0;
    logic          empty1;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;
    logic          out_free;
    logic          legal;
    logic          pop0;
    logic          pop1;

    request_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
        .clk        (clk),
        .rst        (rst),
        .push       (in0_valid),
        .push_data  (in0_data),
        .push_ready (in0_ready),
        .pop        (pop0),
        .head       (head0),
        .empty      (empty0),
        .count      (count0)
    );

    request_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
        .clk        (clk),
        .rst        (rst),
        .push       (in1_valid),
        .push_data  (in1_data),
        .push_ready (in1_ready),
        .pop        (pop1),
        .head       (head1),
        .empty      (empty1),
        .count      (count1)
    );

    assign out_free = !out_valid || out_ready;
    assign requests = {!empty1 && out_free, !empty0 && out_free};

    // Only a one-hot grant that matches a live request is honoured.
    assign legal = ((grants == 2'b01) && requests[CLIENT0]) ||
                   ((grants == 2'b10) && requests[CLIENT1]);
    assign pop0  = legal && grants[CLIENT0];
    assign pop1  = legal && grants[CLIENT1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_src        <= CLIENT0;
            protocol_error <= 1'b0;
        end else begin
            if (legal) begin
                out_valid <= 1'b1;
                out_data  <= grants[CLIENT1] ? head1 : head0;
                out_src   <= grants[CLIENT1] ? CLIENT1 : CLIENT0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if ((grants != 2'b00) && !legal) begin
                protocol_error <= 1'b1;
            end
        end
    end

    count_bound_a : assert property (@(posedge clk) disable iff (!rst)
        (count0 <= DEPTH_C) && (count1 <= DEPTH_C));

endmodule

// File: tb/tb_arbiter_request_front_end.sv
// Directed bench for arbiter_request_front_end: inputs driven and outputs sampled 1ns after posedge.
module tb_arbiter_request_front_end;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0_valid;
    logic       in0_ready;
    logic [7:0] in0_data;
    logic       in1_valid;
    logic       in1_ready;
    logic [7:0] in1_data;
    logic [1:0] requests;
    logic [1:0] grants;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_src;
    logic       protocol_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arbiter_request_front_end #(.W(8), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in0_valid      (in0_valid),
        .in0_ready      (in0_ready),
        .in0_data       (in0_data),
        .in1_valid      (in1_valid),
        .in1_ready      (in1_ready),
        .in1_data       (in1_data),
        .requests       (requests),
        .grants         (grants),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_src        (out_src),
        .protocol_error (protocol_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in0_valid = 0; in1_valid = 0; in0_data = '0; in1_data = '0;
        grants = 2'b00; out_ready = 1'b0;
        #12;
        checks++; if ({in0_ready, in1_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", {in0_ready, in1_ready}); end
        checks++; if (requests !== 2'b00) begin errors++; $display("FAIL reset_requests got %b want 00", requests); end
        checks++; if ({out_valid, out_data, out_src, protocol_error} !== 11'h0) begin errors++; $display("FAIL reset_out got v=%b d=%h s=%b e=%b want all 0", out_valid, out_data, out_src, protocol_error); end
        @(negedge clk); rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        in0_valid = 1; in0_data = 8'hA1;
        step();
        in0_valid = 0;
        checks++; if (requests !== 2'b01) begin errors++; $display("FAIL single_req got %b want 01", requests); end
        grants = 2'b01;
        step();
        grants = 2'b00;
        checks++; if ({out_valid, out_data, out_src} !== {1'b1, 8'hA1, 1'b0}) begin errors++; $display("FAIL single_out got v=%b d=%h s=%b want 1 a1 0", out_valid, out_data, out_src); end
        checks++; if (requests !== 2'b00) begin errors++; $display("FAIL single_req_after got %b want 00", requests); end
        out_ready = 1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            in1_valid = 1; in1_data = 8'h10 + 8'(k);
            step();
        end
        checks++; if (in1_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %b want 0", in1_ready); end
        in1_data = 8'h14;
        step();
        in1_valid = 0;
        checks++; if (in1_ready !== 1'b0) begin errors++; $display("FAIL fill_still_full got %b want 0", in1_ready); end
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (requests !== 2'b10) begin errors++; $display("FAIL fill_req%0d got %b want 10", k, requests); end
            grants = 2'b10;
            step();
            checks++; if ({out_valid, out_data, out_src} !== {1'b1, 8'h10 + 8'(k), 1'b1}) begin errors++; $display("FAIL fill_out%0d got v=%b d=%h s=%b want 1 %h 1", k, out_valid, out_data, out_src, 8'h10 + 8'(k)); end
            if (k == 0) begin
                checks++; if (in1_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_rise got %b want 1", in1_ready); end
            end
        end
        grants = 2'b00;
        checks++; if (requests !== 2'b00) begin errors++; $display("FAIL fill_no_fifth got %b want 00", requests); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_drain got %b want 0", out_valid); end
    endtask

    task automatic test_interleave();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h20; exp_d[1] = 8'h30; exp_d[2] = 8'h21; exp_d[3] = 8'h31;
        for (int k = 0; k < 2; k++) begin
            in0_valid = 1; in0_data = 8'h20 + 8'(k);
            in1_valid = 1; in1_data = 8'h30 + 8'(k);
            step();
        end
        in0_valid = 0; in1_valid = 0;
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            grants = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if ((requests & grants) !== grants) begin errors++; $display("FAIL ilv_req%0d got %b want %b set", k, requests, grants); end
            step();
            checks++; if ({out_valid, out_data, out_src} !== {1'b1, exp_d[k], 1'(k % 2)}) begin errors++; $display("FAIL ilv_out%0d got v=%b d=%h s=%b want 1 %h %0d", k, out_valid, out_data, out_src, exp_d[k], k % 2); end
        end
        grants = 2'b00;
        step();
        checks++; if ({out_valid, requests} !== 3'b000) begin errors++; $display("FAIL ilv_end got v=%b r=%b want 0 00", out_valid, requests); end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 2; k++) begin
            in0_valid = 1; in0_data = 8'h40 + 8'(k);
            step();
        end
        in0_valid = 0;
        out_ready = 0;
        grants = 2'b01;
        step();
        grants = 2'b00;
        for (int k = 0; k < 5; k++) begin
            checks++; if ({requests, out_valid, out_data} !== {2'b00, 1'b1, 8'h40}) begin errors++; $display("FAIL hold%0d got r=%b v=%b d=%h want 00 1 40", k, requests, out_valid, out_data); end
            step();
        end
        out_ready = 1; #1;
        checks++; if (requests !== 2'b01) begin errors++; $display("FAIL hold_release_req got %b want 01", requests); end
        grants = 2'b01;
        step();
        grants = 2'b00;
        checks++; if ({out_valid, out_data, out_src} !== {1'b1, 8'h41, 1'b0}) begin errors++; $display("FAIL hold_b2b got v=%b d=%h s=%b want 1 41 0", out_valid, out_data, out_src); end
        step();
        checks++; if ({out_valid, protocol_error} !== 2'b00) begin errors++; $display("FAIL hold_end got v=%b e=%b want 0 0", out_valid, protocol_error); end
    endtask

    task automatic test_error();
        in1_valid = 1; in1_data = 8'h50;
        step();
        in1_valid = 0;
        grants = 2'b11;
        step();
        checks++; if ({protocol_error, out_valid, requests} !== {1'b1, 1'b0, 2'b10}) begin errors++; $display("FAIL err_both got e=%b v=%b r=%b want 1 0 10", protocol_error, out_valid, requests); end
        grants = 2'b00;
        step();
        grants = 2'b01;
        step();
        grants = 2'b00;
        checks++; if ({protocol_error, out_valid, requests} !== {1'b1, 1'b0, 2'b10}) begin errors++; $display("FAIL err_empty got e=%b v=%b r=%b want 1 0 10", protocol_error, out_valid, requests); end
        grants = 2'b10;
        step();
        grants = 2'b00;
        checks++; if ({protocol_error, out_valid, out_data, out_src} !== {1'b1, 1'b1, 8'h50, 1'b1}) begin errors++; $display("FAIL err_sticky got e=%b v=%b d=%h s=%b want 1 1 50 1", protocol_error, out_valid, out_data, out_src); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            in0_valid = 1; in0_data = 8'h60 + 8'(k);
            step();
        end
        in0_valid = 0;
        grants = 2'b01;
        step();
        grants = 2'b00;
        checks++; if ({out_valid, out_data} !== {1'b1, 8'h60}) begin errors++; $display("FAIL mid_pre got v=%b d=%h want 1 60", out_valid, out_data); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({out_valid, out_data, out_src, protocol_error, requests, in0_ready, in1_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b11}) begin
            errors++; $display("FAIL mid_async got v=%b d=%h s=%b e=%b r=%b rdy=%b%b want 0 00 0 0 00 11", out_valid, out_data, out_src, protocol_error, requests, in0_ready, in1_ready);
        end
        @(negedge clk); rst = 1'b1;
        out_ready = 1;
        step();
        checks++; if ({requests, out_valid} !== 3'b000) begin errors++; $display("FAIL mid_after got r=%b v=%b want 00 0", requests, out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_interleave();
        test_hold();
        test_error();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
